// File: rtl/debouncer_pkg.sv
// Shared types, defaults and sizing helpers for the debouncer array and its channels.
package debouncer_pkg;

  localparam int unsigned DefaultChannels     = 4;
  localparam int unsigned DefaultCounterWidth = 16;
  localparam int unsigned DefaultSyncStages   = 2;
  localparam int unsigned DefaultRepeatDelay  = 50000000;
  localparam int unsigned DefaultRepeatPeriod = 10000000;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHold   = 2'd1,
    StRepeat = 2'd2
  } state_e;

  // clog2(max(delay, period)), never narrower than one bit so a 1/1 setup still elaborates
  function automatic int unsigned timer_width(input int unsigned delay,
                                              input int unsigned period);
    int unsigned m;
    m = (delay > period) ? delay : period;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/debouncer_channel.sv
// One debounced input: synchronizer, stable-time counter, edge pulses and hold-to-repeat FSM.
module debouncer_channel
  import debouncer_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = DefaultCounterWidth,
  parameter int unsigned SYNC_STAGES   = DefaultSyncStages,
  parameter int unsigned REPEAT_DELAY  = DefaultRepeatDelay,
  parameter int unsigned REPEAT_PERIOD = DefaultRepeatPeriod
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in,
  input  logic repeat_enable,
  output logic out,
  output logic rise,
  output logic fall,
  output logic press
);

  localparam int unsigned TimerWidth = timer_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [TimerWidth-1:0] DelayLast  = TimerWidth'(REPEAT_DELAY - 1);
  localparam logic [TimerWidth-1:0] PeriodLast = TimerWidth'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0]   sync_q;
  logic [COUNTER_WIDTH-1:0] count_q;
  logic                     out_q, rise_q, fall_q, press_q;
  state_e                   state_q;
  logic [TimerWidth-1:0]    timer_q;

  logic sync;
  logic flip;
  logic go_high;
  logic go_low;

  assign sync    = sync_q[SYNC_STAGES-1];
  // The output only moves on the edge where a full stable window has elapsed.
  assign flip    = (sync != out_q) && (&count_q);
  assign go_high = flip && sync;
  assign go_low  = flip && !sync;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      count_q <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      rise_q <= go_high;
      fall_q <= go_low;
      if (sync == out_q) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
        if (flip) begin
          out_q <= sync;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      // A release wins over any repeat that happens to fall due on the same edge.
      if (go_low) begin
        state_q <= StIdle;
        timer_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (go_high) begin
              press_q <= 1'b1;
              timer_q <= '0;
              state_q <= StHold;
            end
          end
          StHold: begin
            if (!repeat_enable) begin
              timer_q <= '0;
            end else if (timer_q == DelayLast) begin
              press_q <= 1'b1;
              timer_q <= '0;
              state_q <= StRepeat;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          StRepeat: begin
            if (!repeat_enable) begin
              timer_q <= '0;
              state_q <= StHold;
            end else if (timer_q == PeriodLast) begin
              press_q <= 1'b1;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            timer_q <= '0;
          end
        endcase
      end
    end
  end

  assign out   = out_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign press = press_q;

endmodule

// File: rtl/debouncer_array.sv
// Bank of independent debounced inputs with edge and auto-repeat press pulses.
module debouncer_array
  import debouncer_pkg::*;
#(
  parameter int unsigned CHANNELS      = DefaultChannels,
  parameter int unsigned COUNTER_WIDTH = DefaultCounterWidth,
  parameter int unsigned SYNC_STAGES   = DefaultSyncStages,
  parameter int unsigned REPEAT_DELAY  = DefaultRepeatDelay,
  parameter int unsigned REPEAT_PERIOD = DefaultRepeatPeriod
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] in,
  input  logic                repeat_enable,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] press
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
    debouncer_channel #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .SYNC_STAGES   (SYNC_STAGES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_channel (
      .clock         (clock),
      .reset_n       (reset_n),
      .in            (in[i]),
      .repeat_enable (repeat_enable),
      .out           (out[i]),
      .rise          (rise[i]),
      .fall          (fall[i]),
      .press         (press[i])
    );
  end

endmodule

// File: tb/tb_debouncer_array.sv
// Directed and randomized checks of debouncer_array against a cycle-level behavioural model.
module tb_debouncer_array;

  localparam int unsigned CH = 2;
  localparam int unsigned CW = 2;
  localparam int unsigned SS = 2;
  localparam int unsigned RD = 5;
  localparam int unsigned RP = 3;
  localparam int unsigned Stable = 1 << CW;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [CH-1:0] in;
  logic          repeat_enable;
  logic [CH-1:0] out, rise, fall, press;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  int press0_q[$], rise0_q[$], fall0_q[$], fall1_q[$];

  // Behavioural model: history of sampled input, run of differing edges, repeat streak.
  bit m_sync[CH][SS];
  int m_run[CH];
  bit m_out[CH], m_rise[CH], m_fall[CH], m_press[CH];
  bit m_held[CH], m_first[CH];
  int m_streak[CH];

  always #5 clock = ~clock;

  debouncer_array #(
    .CHANNELS      (CH),
    .COUNTER_WIDTH (CW),
    .SYNC_STAGES   (SS),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in            (in),
    .repeat_enable (repeat_enable),
    .out           (out),
    .rise          (rise),
    .fall          (fall),
    .press         (press)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < SS; k++) m_sync[c][k] = 1'b0;
      m_run[c] = 0;
      m_out[c] = 1'b0;  m_rise[c] = 1'b0; m_fall[c] = 1'b0; m_press[c] = 1'b0;
      m_held[c] = 1'b0; m_first[c] = 1'b1; m_streak[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      bit s;
      s = m_sync[c][SS-1];
      m_rise[c]  = 1'b0;
      m_fall[c]  = 1'b0;
      m_press[c] = 1'b0;
      // Output follows the synchronized level once it has differed for Stable edges in a row.
      if (s != m_out[c]) begin
        m_run[c]++;
        if (m_run[c] == Stable) begin
          m_out[c] = s;
          m_run[c] = 0;
          if (s) m_rise[c] = 1'b1;
          else   m_fall[c] = 1'b1;
        end
      end else begin
        m_run[c] = 0;
      end
      if (m_fall[c]) begin
        m_held[c] = 1'b0;
      end else if (m_rise[c]) begin
        m_held[c] = 1'b1; m_press[c] = 1'b1; m_streak[c] = 0; m_first[c] = 1'b1;
      end else if (m_held[c]) begin
        if (!repeat_enable) begin
          m_streak[c] = 0; m_first[c] = 1'b1;
        end else begin
          m_streak[c]++;
          if (m_streak[c] == (m_first[c] ? RD : RP)) begin
            m_press[c] = 1'b1; m_streak[c] = 0; m_first[c] = 1'b0;
          end
        end
      end
      for (int k = SS - 1; k > 0; k--) m_sync[c][k] = m_sync[c][k-1];
      m_sync[c][0] = in[c];
    end
  endtask

  function automatic logic [4*CH-1:0] model_vec();
    logic [4*CH-1:0] v;
    for (int c = 0; c < CH; c++) begin
      v[c]        = m_out[c];
      v[CH+c]     = m_rise[c];
      v[2*CH+c]   = m_fall[c];
      v[3*CH+c]   = m_press[c];
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    if (!reset_n) model_reset();
    else begin
      model_step();
      edge_n++;
    end
    @(negedge clock);
    check_eq("cycle", 32'({press, fall, rise, out}), 32'(model_vec()));
    if (press[0]) press0_q.push_back(edge_n);
    if (rise[0])  rise0_q.push_back(edge_n);
    if (fall[0])  fall0_q.push_back(edge_n);
    if (fall[1])  fall1_q.push_back(edge_n);
  endtask

  task automatic clear_logs();
    press0_q.delete(); rise0_q.delete(); fall0_q.delete(); fall1_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in = '0;
    repeat_enable = 1'b0;
    model_reset();
    repeat (2) step();
    check_eq("reset_state", 32'({press, fall, rise, out}), 32'd0);
    reset_n = 1'b1;
    edge_n = 0;
    clear_logs();
  endtask

  initial begin
    int hold[CH];

    // 1: single press latency, other channel quiet
    do_reset();
    in[0] = 1'b1;
    repeat (9) step();
    check_eq("t1_rise_edge", qat(rise0_q, 0), 6);
    check_eq("t1_press_edge", qat(press0_q, 0), 6);
    check_eq("t1_press_count", press0_q.size(), 1);
    in[0] = 1'b0;
    repeat (10) step();

    // 2: glitch shorter than the stable window is ignored
    do_reset();
    in[0] = 1'b1;
    repeat (3) step();
    in[0] = 1'b0;
    repeat (10) step();
    check_eq("t2_no_rise", rise0_q.size(), 0);
    check_eq("t2_no_press", press0_q.size(), 0);

    // 3: auto-repeat; the repeat due on the release edge is suppressed
    do_reset();
    repeat_enable = 1'b1;
    in[0] = 1'b1;
    repeat (20) step();
    in[0] = 1'b0;
    repeat (10) step();
    check_eq("t3_press1", qat(press0_q, 1), 11);
    check_eq("t3_press2", qat(press0_q, 2), 14);
    check_eq("t3_press3", qat(press0_q, 3), 17);
    check_eq("t3_press_count", press0_q.size(), 6);
    check_eq("t3_last_press", qat(press0_q, 5), 23);
    check_eq("t3_fall_edge", qat(fall0_q, 0), 26);

    // 4: repeat gated off, then enabled after edge 20
    do_reset();
    in[0] = 1'b1;
    repeat (20) step();
    repeat_enable = 1'b1;
    repeat (7) step();
    check_eq("t4_press_count", press0_q.size(), 2);
    check_eq("t4_second_press", qat(press0_q, 1), 25);

    // 5: opposite simultaneous changes on both channels
    do_reset();
    in = 2'b10;
    repeat (10) step();
    clear_logs();
    in = 2'b01;
    repeat (10) step();
    check_eq("t5_rise0", qat(rise0_q, 0), 16);
    check_eq("t5_fall1", qat(fall1_q, 0), 16);

    // 6: asynchronous reset mid-cycle during REPEAT
    do_reset();
    repeat_enable = 1'b1;
    in[0] = 1'b1;
    repeat (13) step();
    #2 reset_n = 1'b0;
    #1 check_eq("t6_async_clear", 32'({press, fall, rise, out}), 32'd0);
    model_reset();
    step();
    reset_n = 1'b1;
    edge_n = 0;
    clear_logs();
    repeat (8) step();
    check_eq("t6_rise_edge", qat(rise0_q, 0), 6);
    check_eq("t6_press_edge", qat(press0_q, 0), 6);

    // Randomized soak against the model
    do_reset();
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          in[c] = ~in[c];
          hold[c] = $urandom_range(1, 12);
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 39) == 0) repeat_enable = ~repeat_enable;
      if ($urandom_range(0, 249) == 0) begin
        #2 reset_n = 1'b0;
        #1 check_eq("rnd_async_clear", 32'({press, fall, rise, out}), 32'd0);
        model_reset();
        step();
        reset_n = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debouncer_array.md
Name: debouncer_array

Overview:
- Multi-channel successor to the single-input debouncer, for banks of push-buttons and switches that feed the seven-segment controller's digit-edit and mode logic.
- Each channel has a synchronizer of parameterized depth, a stable-time counter, and registered rise/fall edge pulses.
- Each channel also has a hold-to-repeat state machine that emits "press" pulses, giving increment/decrement buttons auto-repeat without extra logic downstream.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- COUNTER_WIDTH, 16: stable-time counter width; the input must hold a new level for 2^COUNTER_WIDTH cycles before the output changes.
- SYNC_STAGES, 2: synchronizer flop depth (>=2).
- REPEAT_DELAY, 50000000: cycles a debounced level must stay high before the first auto-repeat pulse (>=1).
- REPEAT_PERIOD, 10000000: cycles between subsequent auto-repeat pulses (>=1).

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  CHANNELS  raw asynchronous inputs; bit i belongs to channel i.
- repeat_enable  input  1  global auto-repeat enable, sampled each clock.
- out  output  CHANNELS  debounced levels.
- rise  output  CHANNELS  one-cycle pulse when out[i] goes 0->1.
- fall  output  CHANNELS  one-cycle pulse when out[i] goes 1->0.
- press  output  CHANNELS  one-cycle pulse on each rise, plus each auto-repeat event.

Behaviour:
- Reset (reset_n low, asynchronous): clears synchronizers, counters, repeat timers, and all outputs to 0. All FSMs go to IDLE. Reset may assert mid-count or mid-repeat; no pulse is emitted on reset entry or exit.
- Channels are fully independent. A simultaneous change on every channel behaves exactly like each channel alone.
- Synchronizer: shift register of SYNC_STAGES flops; the last stage, sync[i], drives all downstream logic.
- Counter, when sync[i] == out[i]: counter clears to 0.
- Counter, when sync[i] != out[i]: counter increments. On the edge where counter == all-ones, out[i] <= sync[i] and counter wraps to 0.
- A glitch shorter than the count restarts the counter from 0 when it reverts.
- Latency: an input change stable from before edge 1 appears on out[i] at rising edge SYNC_STAGES + 2^COUNTER_WIDTH.
- rise[i] / fall[i] are registered and set on the same edge out[i] updates, so each is high for exactly the first cycle of the new out level.
- Per-channel FSM, states IDLE, HOLD, REPEAT; timer width is clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- IDLE: on the edge where out[i] goes 0->1, press[i] pulses (coincident with rise[i]), timer <= 0, go to HOLD.
- HOLD: if repeat_enable is high, timer increments. When timer == REPEAT_DELAY-1, press[i] pulses, timer <= 0, go to REPEAT. If repeat_enable is low, timer holds at 0.
- REPEAT: timer increments. When timer == REPEAT_PERIOD-1, press[i] pulses and timer <= 0. If repeat_enable is low, go to HOLD with timer <= 0.
- Any state: on the edge where out[i] goes 1->0, go to IDLE with timer <= 0, and no press that cycle, even if a repeat is due on the same edge.
- REPEAT_DELAY = 1: first repeat comes one cycle after the initial press. REPEAT_PERIOD = 1: press stays high continuously while in REPEAT.
- Counter overflow cannot occur; wrap is by design, at out update only.

Decomposition:
- Package debouncer_pkg holds:
  - the FSM state typedef (IDLE, HOLD, REPEAT; 2-bit encoding);
  - a clog2/max helper for the timer width;
  - default constants for the parameters.
- One natural sub-module, debouncer_channel: synchronizer, counter, edge regs, and FSM for a single bit. The top instantiates it CHANNELS times via a generate loop and contains no other logic.

Test Plan (CHANNELS=2, COUNTER_WIDTH=2, SYNC_STAGES=2, REPEAT_DELAY=5, REPEAT_PERIOD=3):
1. Reset, then set in[0]=1 before edge 1 -> out[0] rises at edge 6. rise[0] and press[0] are high for exactly cycle 6-7; out[1], rise[1], fall[1], press[1] stay 0.
2. in[0] pulses 1 for 3 cycles then returns to 0 -> out, rise, and press never assert. The counter restarts at 0 on the revert.
3. repeat_enable=1, hold in[0]=1 -> press[0] at edge 6, then edges 11, 14, 17, ... Releasing the input gives fall[0] 6 edges after the release and no further press.
4. repeat_enable=0 while held -> only the initial press at edge 6. Raising repeat_enable at edge 20 gives the next press at edge 25.
5. Both channels change on the same cycle, in opposite directions -> rise[0] and fall[1] pulse on the same edge, and each channel's timing matches its single-channel case.
6. Drop reset_n asynchronously, mid-cycle, during REPEAT -> all outputs go 0 immediately. After release with the input still high, out returns at edge 6 with a fresh press.
